conv_multadd_acc: RTL and testbench

CONV_MULTADD_ACC -- requirements
Module: conv_multadd_acc

---
 rtl/conv_multadd_pkg.sv | 31 +++
 rtl/conv_multadd_tree.sv | 59 +++++
 rtl/conv_multadd_acc.sv | 175 +++++++++++++++++
 tb/tb_conv_multadd_acc.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/conv_multadd_pkg.sv
`default_nettype none
// ============================================================================
// Module : conv_multadd_pkg
// Brief  : Shared constants, clog2 helper and frame FSM state type for the
//          conv_multadd accumulator slice.
// Rev    : 1.0 - initial release
// ============================================================================
package conv_multadd_pkg;

    localparam int DEF_ASIZE = 8;
    localparam int DEF_BSIZE = 8;
    localparam int DEF_NTERM = 9;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_ACCUM = 1'b1
    } frame_state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/conv_multadd_tree.sv
`default_nettype none
// ============================================================================
// Module : conv_multadd_tree
// Brief  : Signed reduction of NTERM packed product terms into one registered
//          beat sum; carries the beat's valid/first/last flags alongside.
// Rev    : 1.0 - initial release
// ============================================================================
module conv_multadd_tree
    import conv_multadd_pkg::*;
#(
    parameter int NTERM = DEF_NTERM,
    parameter int IN_W  = 18,
    parameter int OUT_W = IN_W + clog2(NTERM)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ce,
    input  logic                    in_valid,
    input  logic                    in_first,
    input  logic                    in_last,
    input  logic [NTERM*IN_W-1:0]   terms,
    output logic                    out_valid,
    output logic                    out_first,
    output logic                    out_last,
    output logic signed [OUT_W-1:0] sum
);

    logic signed [OUT_W-1:0] sum_d, sum_q;
    logic                    valid_q, first_q, last_q;

    // OUT_W carries clog2(NTERM) guard bits, so the reduction cannot overflow.
    always_comb begin
        sum_d = '0;
        for (int k = 0; k < NTERM; k++) begin
            sum_d = sum_d + OUT_W'($signed(terms[k*IN_W +: IN_W]));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q   <= '0;
            valid_q <= 1'b0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
        end else if (ce) begin
            sum_q   <= sum_d;
            valid_q <= in_valid;
            first_q <= in_first;
            last_q  <= in_last;
        end
    end

    assign sum       = sum_q;
    assign out_valid = valid_q;
    assign out_first = first_q;
    assign out_last  = last_q;

endmodule
`default_nettype wire

// File: rtl/conv_multadd_acc.sv
`default_nettype none
// ============================================================================
// Module : conv_multadd_acc
// Brief  : Three-stage multiply / signed add tree / framed accumulator.
//          Optional macro CONV_MULTADD_SAT_EN selects saturating accumulate
//          (default build wraps modulo 2^ACC_SIZE).
// Rev    : 1.0 - initial release
// ============================================================================
module conv_multadd_acc
    import conv_multadd_pkg::*;
#(
    parameter int ASIZE    = DEF_ASIZE,
    parameter int BSIZE    = DEF_BSIZE,
    parameter int NTERM    = DEF_NTERM,
    parameter int A_SIGNED = 0,
    parameter int B_SIGNED = 0,
    parameter int ACC_SIZE = ASIZE + BSIZE + clog2(NTERM) + 9
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       ce,
    input  logic                       in_valid,
    input  logic [NTERM*ASIZE-1:0]     a,
    input  logic [NTERM*BSIZE-1:0]     b,
    input  logic [NTERM-1:0]           sub_mask,
    input  logic                       acc_first,
    input  logic                       acc_last,
    output logic                       out_valid,
    output logic signed [ACC_SIZE-1:0] p,
    output logic                       ovf
);

    localparam int PROD_W = ASIZE + BSIZE + 2;
    localparam int SUM_W  = PROD_W + clog2(NTERM);
    localparam int EXT_W  = ((ACC_SIZE > SUM_W) ? ACC_SIZE : SUM_W) + 1;

    localparam logic signed [EXT_W-1:0] C_ACC_MAX =
        {{(EXT_W-ACC_SIZE+1){1'b0}}, {(ACC_SIZE-1){1'b1}}};
    localparam logic signed [EXT_W-1:0] C_ACC_MIN =
        {{(EXT_W-ACC_SIZE+1){1'b1}}, {(ACC_SIZE-1){1'b0}}};

    // ---------------- S1: signed products ----------------
    logic [NTERM*PROD_W-1:0] prod_d, prod_q;
    logic                    s1_valid_q, s1_first_q, s1_last_q;
    logic signed [ASIZE:0]   a_ext;
    logic signed [BSIZE:0]   b_ext;
    logic signed [PROD_W-1:0] term;

    // One extra bit per operand lets signed and unsigned share one multiplier.
    always_comb begin
        prod_d = '0;
        a_ext  = '0;
        b_ext  = '0;
        term   = '0;
        for (int k = 0; k < NTERM; k++) begin
            a_ext = (A_SIGNED != 0) ? {a[k*ASIZE+ASIZE-1], a[k*ASIZE +: ASIZE]}
                                    : {1'b0, a[k*ASIZE +: ASIZE]};
            b_ext = (B_SIGNED != 0) ? {b[k*BSIZE+BSIZE-1], b[k*BSIZE +: BSIZE]}
                                    : {1'b0, b[k*BSIZE +: BSIZE]};
            term  = PROD_W'(a_ext) * PROD_W'(b_ext);
            if (sub_mask[k]) begin
                term = -term;
            end
            prod_d[k*PROD_W +: PROD_W] = term;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prod_q     <= '0;
            s1_valid_q <= 1'b0;
            s1_first_q <= 1'b0;
            s1_last_q  <= 1'b0;
        end else if (ce) begin
            prod_q     <= prod_d;
            s1_valid_q <= in_valid;
            s1_first_q <= acc_first;
            s1_last_q  <= acc_last;
        end
    end

    // ---------------- S2: adder tree ----------------
    logic                    s2_valid, s2_first, s2_last;
    logic signed [SUM_W-1:0] s2_sum;

    conv_multadd_tree #(
        .NTERM (NTERM),
        .IN_W  (PROD_W),
        .OUT_W (SUM_W)
    ) u_tree (
        .clk       (clk),
        .rst       (rst),
        .ce        (ce),
        .in_valid  (s1_valid_q),
        .in_first  (s1_first_q),
        .in_last   (s1_last_q),
        .terms     (prod_q),
        .out_valid (s2_valid),
        .out_first (s2_first),
        .out_last  (s2_last),
        .sum       (s2_sum)
    );

    // ---------------- S3: frame accumulator ----------------
    frame_state_t                state_d, state_q;
    logic signed [ACC_SIZE-1:0]  acc_d, acc_q, p_d, p_q, base, acc_next;
    logic                        sticky_d, sticky_q, ovf_d, ovf_q;
    logic                        out_valid_d, out_valid_q;
    logic                        fresh, base_ovf, step_ovf;
    logic signed [EXT_W-1:0]     wide;

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        sticky_d    = sticky_q;
        p_d         = p_q;
        ovf_d       = ovf_q;
        out_valid_d = 1'b0;

        // A new frame starts from zero whether opened explicitly or from IDLE.
        fresh    = (state_q == ST_IDLE) || s2_first;
        base     = fresh ? '0 : acc_q;
        base_ovf = fresh ? 1'b0 : sticky_q;
        wide     = EXT_W'(base) + EXT_W'(s2_sum);
        step_ovf = (wide > C_ACC_MAX) || (wide < C_ACC_MIN);
`ifdef CONV_MULTADD_SAT_EN
        if (step_ovf) begin
            acc_next = wide[EXT_W-1] ? C_ACC_MIN[ACC_SIZE-1:0] : C_ACC_MAX[ACC_SIZE-1:0];
        end else begin
            acc_next = wide[ACC_SIZE-1:0];
        end
`else
        acc_next = wide[ACC_SIZE-1:0];
`endif

        if (s2_valid) begin
            if (s2_last) begin
                out_valid_d = 1'b1;
                p_d         = acc_next;
                ovf_d       = base_ovf | step_ovf;
                acc_d       = '0;
                sticky_d    = 1'b0;
                state_d     = ST_IDLE;
            end else begin
                acc_d       = acc_next;
                sticky_d    = base_ovf | step_ovf;
                state_d     = ST_ACCUM;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            acc_q       <= '0;
            sticky_q    <= 1'b0;
            p_q         <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else if (ce) begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            sticky_q    <= sticky_d;
            p_q         <= p_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid = out_valid_q;
    assign p         = p_q;
    assign ovf       = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_conv_multadd_acc.sv
`default_nettype none
// ============================================================================
// Module : tb_conv_multadd_acc
// Brief  : Directed scoreboard bench: 26-bit and 18-bit accumulator instances.
// Rev    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_conv_multadd_acc;

    localparam int NT = 4;
    localparam int AW = 8;
    localparam int BW = 8;

    localparam logic [31:0] C_A70 = 32'h0403_0201;
    localparam logic [31:0] C_B70 = 32'h0807_0605;
    localparam logic [31:0] C_ALL = 32'hFFFF_FFFF;

    logic              clk = 1'b0;
    logic              rst, ce, v_m, v_s, first, last;
    logic [NT*AW-1:0]  a;
    logic [NT*BW-1:0]  b;
    logic [NT-1:0]     sub_mask;

    logic              ov_m, ovf_m, ov_s, ovf_s;
    logic signed [25:0] p_m;
    logic signed [17:0] p_s;

    typedef struct {
        int p;
        bit o;
        int due;
    } exp_t;

    exp_t q_m[$];
    exp_t q_s[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    conv_multadd_acc #(
        .ASIZE(AW), .BSIZE(BW), .NTERM(NT), .A_SIGNED(0), .B_SIGNED(0), .ACC_SIZE(26)
    ) dut (
        .clk(clk), .rst(rst), .ce(ce), .in_valid(v_m), .a(a), .b(b),
        .sub_mask(sub_mask), .acc_first(first), .acc_last(last),
        .out_valid(ov_m), .p(p_m), .ovf(ovf_m)
    );

    conv_multadd_acc #(
        .ASIZE(AW), .BSIZE(BW), .NTERM(NT), .A_SIGNED(0), .B_SIGNED(0), .ACC_SIZE(18)
    ) dut18 (
        .clk(clk), .rst(rst), .ce(ce), .in_valid(v_s), .a(a), .b(b),
        .sub_mask(sub_mask), .acc_first(first), .acc_last(last),
        .out_valid(ov_s), .p(p_s), .ovf(ovf_s)
    );

    task automatic chk(input string tag, input logic signed [63:0] got,
                       input logic signed [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit tm, input bit ts, input bit f, input bit l,
                         input logic [31:0] av, input logic [31:0] bv,
                         input logic [3:0] sm);
        v_m      = tm;
        v_s      = ts;
        first    = f;
        last     = l;
        a        = av;
        b        = bv;
        sub_mask = sm;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    endtask

    task automatic push_m(input int pv, input bit ov, input int lat);
        exp_t e;
        e.p = pv; e.o = ov; e.due = cyc + lat;
        q_m.push_back(e);
    endtask

    task automatic push_s(input int pv, input bit ov, input int lat);
        exp_t e;
        e.p = pv; e.o = ov; e.due = cyc + lat;
        q_s.push_back(e);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (ov_m === 1'b1) begin
            if (q_m.size() == 0) begin
                chk("m_unexpected_out_valid", ov_m, 0);
            end else begin
                e = q_m.pop_front();
                chk("m_p", p_m, e.p);
                chk("m_ovf", ovf_m, e.o);
                chk("m_latency_cycle", cyc, e.due);
            end
        end
        if (ov_s === 1'b1) begin
            if (q_s.size() == 0) begin
                chk("s_unexpected_out_valid", ov_s, 0);
            end else begin
                e = q_s.pop_front();
                chk("s_p", p_s, e.p);
                chk("s_ovf", ovf_s, e.o);
                chk("s_latency_cycle", cyc, e.due);
            end
        end
    end

    initial begin
        rst = 1'b1;
        ce  = 1'b1;
        idle();
        repeat (3) tick();
        rst = 1'b0;
        chk("rst_out_valid", ov_m, 0);
        chk("rst_p", p_m, 0);
        chk("rst_ovf", ovf_m, 0);
        chk("rst18_out_valid", ov_s, 0);
        chk("rst18_p", p_s, 0);
        chk("rst18_ovf", ovf_s, 0);

        // Single-beat frames back to back: plain sum, then term 1 subtracted.
        drive(1, 0, 1, 1, C_A70, C_B70, 4'b0000); push_m(70, 0, 3); tick();
        drive(1, 0, 1, 1, C_A70, C_B70, 4'b0010); push_m(46, 0, 3); tick();
        idle(); repeat (5) tick();

        // Three-beat all-ones frame with an in_valid bubble before the last beat.
        drive(1, 0, 1, 0, C_ALL, C_ALL, 4'b0000); tick();
        drive(1, 0, 0, 0, C_ALL, C_ALL, 4'b0000); tick();
        idle(); tick();
        drive(1, 0, 0, 1, C_ALL, C_ALL, 4'b0000); push_m(780300, 0, 3); tick();
        idle(); repeat (5) tick();

        // Same frame with a two-cycle clock-enable stall while it is in flight.
        drive(1, 0, 1, 0, C_ALL, C_ALL, 4'b0000); tick();
        drive(1, 0, 0, 0, C_ALL, C_ALL, 4'b0000); tick();
        drive(1, 0, 0, 1, C_ALL, C_ALL, 4'b0000); push_m(780300, 0, 5); tick();
        idle();
        ce = 1'b0; repeat (2) tick();
        ce = 1'b1; repeat (6) tick();

        // Reset mid-frame drops the partial frame; only the following beat emits.
        drive(1, 0, 1, 0, C_ALL, C_ALL, 4'b0000); tick();
        drive(1, 0, 0, 0, C_ALL, C_ALL, 4'b0000); tick();
        idle(); rst = 1'b1; tick();
        rst = 1'b0;
        chk("midrst_p_cleared", p_m, 0);
        drive(1, 0, 1, 1, C_A70, C_B70, 4'b0000); push_m(70, 0, 3); tick();
        idle(); repeat (6) tick();

        // acc_first during an open frame discards the partial sum.
        drive(1, 0, 1, 0, C_ALL, C_ALL, 4'b0000); tick();
        drive(1, 0, 1, 1, C_A70, C_B70, 4'b0000); push_m(70, 0, 3); tick();
        idle(); repeat (6) tick();

        // From IDLE without acc_first, all terms subtracted: negative result.
        drive(1, 0, 0, 1, C_A70, C_B70, 4'b1111); push_m(-70, 0, 3); tick();
        idle(); repeat (6) tick();

        // 18-bit instance: overflowing beat, then a clean frame clears ovf.
`ifdef CONV_MULTADD_SAT_EN
        drive(0, 1, 1, 1, C_ALL, C_ALL, 4'b0000); push_s(131071, 1, 3); tick();
`else
        drive(0, 1, 1, 1, C_ALL, C_ALL, 4'b0000); push_s(-2044, 1, 3); tick();
`endif
        drive(0, 1, 1, 1, C_A70, C_B70, 4'b0000); push_s(70, 0, 3); tick();
        idle(); repeat (8) tick();

        chk("m_queue_drained", q_m.size(), 0);
        chk("s_queue_drained", q_s.size(), 0);
        chk("hold_out_valid", ov_m, 0);
        chk("hold_p", p_m, -70);
        chk("hold_ovf", ovf_m, 0);
        chk("hold18_p", p_s, 70);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
